// File: rtl/definitions_pkg.sv
// Shared chip-level definitions: clock/baud rates and UART types.
// Provides uart_parity_e, the TX/RX state enums and UART_DEFAULT_DIV.
package definitions_pkg;

    localparam int CLOCK_RATE = 50_000_000;
    localparam int BAUD_RATE  = 115_200;

    localparam int OVERSAMPLE       = 16;
    localparam int UART_DEFAULT_DIV =
        CLOCK_RATE / (BAUD_RATE * OVERSAMPLE) - 1;

    typedef enum logic [1:0] {
        PARITY_NONE,
        PARITY_EVEN,
        PARITY_ODD
    } uart_parity_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } uart_tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } uart_rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator shared by the UART transmitter and receiver.
// Ports: clk, rst (async high), baud_div (cycles per tick - 1), tick (1-clk pulse).
module uart_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] baud_div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;

    // >= rather than == so a lowered divisor cannot strand the counter.
    always_comb begin
        tick  = (cnt_q >= baud_div);
        cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: runtime baud divisor, 16x oversampled RX.
// Ports: clk, rst, baudDiv, rxEnabled/txEnabled, txStart/txData -> tx,
//   txBusy, txDone; rx -> rxData, rxBusy, rxDone, rxFrameErr, rxParityErr.
// Define UART_PARITY_EN to enable the PARITY_MODE parity bit.
module uart_core_param
    import definitions_pkg::*;
#(
    parameter int           DATA_BITS   = 8,
    parameter int           STOP_BITS   = 1,
    parameter uart_parity_e PARITY_MODE = PARITY_NONE,
    parameter int           DIV_WIDTH   = 16,
    parameter int           DEFAULT_DIV = UART_DEFAULT_DIV
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] baudDiv,
    input  logic                 rxEnabled,
    input  logic                 txEnabled,
    input  logic                 txStart,
    input  logic [DATA_BITS-1:0] txData,
    output logic                 tx,
    output logic                 txBusy,
    output logic                 txDone,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 rxBusy,
    output logic                 rxDone,
    output logic                 rxFrameErr,
    output logic                 rxParityErr
);

`ifdef UART_PARITY_EN
    localparam bit HAS_PAR = (PARITY_MODE != PARITY_NONE);
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    localparam bit       ODD_PAR   = (PARITY_MODE == PARITY_ODD);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    logic tick;

    uart_baud_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .baud_div (baudDiv),
        .tick     (tick)
    );

    // ---------------- transmitter ----------------
    uart_tx_state_e       tx_state_q, tx_state_d;
    logic [3:0]           tx_tcnt_q, tx_tcnt_d;
    logic [3:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_done_q, tx_done_d;
    logic                 tx_out;
    logic                 tx_end;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        tx_done_d  = 1'b0;
        tx_out     = 1'b1;
        tx_end     = tick && (tx_tcnt_q == 4'd15);
        if (tick) begin
            tx_tcnt_d = tx_tcnt_q + 4'd1;
        end
        unique case (tx_state_q)
            TX_IDLE: begin
                if (txStart && txEnabled) begin
                    tx_state_d = TX_START;
                    tx_sh_d    = txData;
                    tx_par_d   = (^txData) ^ ODD_PAR;
                    tx_tcnt_d  = 4'd0;
                end
            end
            TX_START: begin
                tx_out = 1'b0;
                if (tx_end) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = 4'd0;
                end
            end
            TX_DATA: begin
                tx_out = tx_sh_q[0];
                if (tx_end) begin
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_bit_d = tx_bit_q + 4'd1;
                    if (tx_bit_q == LAST_DATA) begin
                        tx_state_d = HAS_PAR ? TX_PARITY : TX_STOP;
                        tx_bit_d   = 4'd0;
                    end
                end
            end
            TX_PARITY: begin
                tx_out = tx_par_q;
                if (tx_end) begin
                    tx_state_d = TX_STOP;
                    tx_bit_d   = 4'd0;
                end
            end
            TX_STOP: begin
                if (tx_end) begin
                    tx_bit_d = tx_bit_q + 4'd1;
                    if (tx_bit_q == LAST_STOP) begin
                        tx_state_d = TX_IDLE;
                        tx_done_d  = 1'b1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_tcnt_q  <= 4'd0;
            tx_bit_q   <= 4'd0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_par_q   <= tx_par_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign tx     = tx_out;
    assign txBusy = (tx_state_q != TX_IDLE);
    assign txDone = tx_done_q;

    // ---------------- receiver ----------------
    uart_rx_state_e       rx_state_q, rx_state_d;
    logic                 rx_s1_q, rx_s2_q;
    logic [3:0]           rx_tcnt_q, rx_tcnt_d;
    logic [3:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic                 rx_pend_q, rx_pend_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_done_q, rx_done_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_end;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_pend_d  = rx_pend_q;
        rx_data_d  = rx_data_q;
        rx_done_d  = 1'b0;
        rx_ferr_d  = 1'b0;
        rx_perr_d  = 1'b0;
        rx_end     = tick && (rx_tcnt_q == 4'd15);
        if (tick) begin
            rx_tcnt_d = rx_tcnt_q + 4'd1;
        end
        if (!rxEnabled) begin
            rx_state_d = RX_IDLE;
        end else begin
            unique case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_s2_q) begin
                        rx_state_d = RX_START;
                        rx_tcnt_d  = 4'd0;
                    end
                end
                // Half a bit in: confirm the start bit is real.
                RX_START: begin
                    if (tick && rx_tcnt_q == 4'd7) begin
                        rx_tcnt_d  = 4'd0;
                        rx_bit_d   = 4'd0;
                        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_end) begin
                        rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
                        rx_bit_d = rx_bit_q + 4'd1;
                        if (rx_bit_q == LAST_DATA) begin
                            rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
                        end
                    end
                end
                RX_PARITY: begin
                    if (rx_end) begin
                        rx_pend_d  = ((^rx_sh_q) ^ rx_s2_q) != ODD_PAR;
                        rx_state_d = RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_end) begin
                        rx_data_d  = rx_sh_q;
                        rx_done_d  = 1'b1;
                        rx_ferr_d  = !rx_s2_q;
                        rx_perr_d  = HAS_PAR && rx_pend_q;
                        rx_state_d = rx_s2_q ? RX_IDLE : RX_BREAK;
                    end
                end
                // Low stop bit: hold off until the line idles high.
                RX_BREAK: begin
                    if (rx_s2_q) begin
                        rx_state_d = RX_IDLE;
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_tcnt_q  <= 4'd0;
            rx_bit_q   <= 4'd0;
            rx_sh_q    <= '0;
            rx_pend_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_done_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_state_q <= rx_state_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_pend_q  <= rx_pend_d;
            rx_data_q  <= rx_data_d;
            rx_done_q  <= rx_done_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

    assign rxData      = rx_data_q;
    assign rxBusy      = (rx_state_q != RX_IDLE);
    assign rxDone      = rx_done_q;
    assign rxFrameErr  = rx_ferr_q;
    assign rxParityErr = rx_perr_q;

endmodule
